// File: rtl/instr_decode.sv
// Instruction decoder: queues fetched words, decodes one at a time and hands it to the CLP.
// Define INSTR_DECODE_OPCODE_CHECK_EN to discard opcodes above 4 and raise a sticky o_err.
module instr_decode #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_instr,
  input  logic [4:0]  i_instr_addr,
  input  logic        i_instr_enable,
  input  logic        i_clp_ready,
  input  logic        i_clp_done,
  output logic        o_valid,
  output logic [6:0]  o_opcode,
  output logic [7:0]  o_feature_size,
  output logic        o_feature_out_select,
  output logic        o_feature_in_select,
  output logic [15:0] o_w_mem_init_addr,
  output logic [7:0]  o_s_mem_addr,
  output logic [15:0] o_clp_work_time,
  output logic [2:0]  o_kernel_size,
  output logic [3:0]  o_clp_type,
  output logic [4:0]  o_instr_addr,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [7:0]  o_retired_cnt,
  output logic        o_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_e;

  state_e      state_q;
  logic [68:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [63:0] head_instr;
  logic [4:0]  head_addr;

  logic        valid_q, busy_q, overflow_q;
  logic [6:0]  opcode_q;
  logic [7:0]  feature_size_q, s_mem_addr_q, retired_cnt_q;
  logic        feature_out_select_q, feature_in_select_q;
  logic [15:0] w_mem_init_addr_q, clp_work_time_q;
  logic [2:0]  kernel_size_q;
  logic [3:0]  clp_type_q;
  logic [4:0]  instr_addr_q;

  // The extra pointer MSB tells a full queue apart from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign fifo_push  = i_instr_enable && (!fifo_full || fifo_pop);
  assign wr_ptr_d   = fifo_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d   = fifo_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  assign head_instr = mem_q[rd_ptr_q[AW-1:0]][68:5];
  assign head_addr  = mem_q[rd_ptr_q[AW-1:0]][4:0];

  // Queue storage; a push at full overwrites the slot being popped the same cycle.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {i_instr, i_instr_addr};
    end
  end

  // Queue pointers and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (i_instr_enable && !fifo_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef INSTR_DECODE_OPCODE_CHECK_EN
  logic err_q;
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // Dispatch FSM with registered decoded fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= IDLE;
      valid_q              <= 1'b0;
      busy_q               <= 1'b0;
      retired_cnt_q        <= 8'd0;
      opcode_q             <= 7'd0;
      feature_size_q       <= 8'd0;
      feature_out_select_q <= 1'b0;
      feature_in_select_q  <= 1'b0;
      w_mem_init_addr_q    <= 16'd0;
      s_mem_addr_q         <= 8'd0;
      clp_work_time_q      <= 16'd0;
      kernel_size_q        <= 3'd0;
      clp_type_q           <= 4'd0;
      instr_addr_q         <= 5'd0;
`ifdef INSTR_DECODE_OPCODE_CHECK_EN
      err_q                <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            opcode_q             <= head_instr[63:57];
            feature_size_q       <= head_instr[56:49];
            feature_out_select_q <= head_instr[48];
            feature_in_select_q  <= head_instr[47];
            w_mem_init_addr_q    <= head_instr[46:31];
            s_mem_addr_q         <= head_instr[30:23];
            clp_work_time_q      <= head_instr[22:7];
            kernel_size_q        <= head_instr[6:4];
            clp_type_q           <= head_instr[3:0];
            instr_addr_q         <= head_addr;
            if (head_instr[63:57] == 7'd0) begin
              state_q <= IDLE;
`ifdef INSTR_DECODE_OPCODE_CHECK_EN
            end else if (head_instr[63:57] > 7'd4) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
`endif
            end else begin
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (i_clp_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (i_clp_done) begin
            retired_cnt_q <= retired_cnt_q + 8'd1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_valid              = valid_q;
  assign o_busy               = busy_q;
  assign o_overflow           = overflow_q;
  assign o_retired_cnt        = retired_cnt_q;
  assign o_opcode             = opcode_q;
  assign o_feature_size       = feature_size_q;
  assign o_feature_out_select = feature_out_select_q;
  assign o_feature_in_select  = feature_in_select_q;
  assign o_w_mem_init_addr    = w_mem_init_addr_q;
  assign o_s_mem_addr         = s_mem_addr_q;
  assign o_clp_work_time      = clp_work_time_q;
  assign o_kernel_size        = kernel_size_q;
  assign o_clp_type           = clp_type_q;
  assign o_instr_addr         = instr_addr_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: queue-based reference model compared every cycle,
// plus directed literal expectations.
module tb_instr_decode;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, i_instr_enable, i_clp_ready, i_clp_done;
  logic [63:0] i_instr;
  logic [4:0]  i_instr_addr;
  logic        o_valid, o_feature_out_select, o_feature_in_select, o_busy, o_overflow, o_err;
  logic [6:0]  o_opcode;
  logic [7:0]  o_feature_size, o_s_mem_addr, o_retired_cnt;
  logic [15:0] o_w_mem_init_addr, o_clp_work_time;
  logic [2:0]  o_kernel_size;
  logic [3:0]  o_clp_type;
  logic [4:0]  o_instr_addr;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  instr_decode #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_instr(i_instr), .i_instr_addr(i_instr_addr),
    .i_instr_enable(i_instr_enable), .i_clp_ready(i_clp_ready), .i_clp_done(i_clp_done),
    .o_valid(o_valid), .o_opcode(o_opcode), .o_feature_size(o_feature_size),
    .o_feature_out_select(o_feature_out_select), .o_feature_in_select(o_feature_in_select),
    .o_w_mem_init_addr(o_w_mem_init_addr), .o_s_mem_addr(o_s_mem_addr),
    .o_clp_work_time(o_clp_work_time), .o_kernel_size(o_kernel_size), .o_clp_type(o_clp_type),
    .o_instr_addr(o_instr_addr), .o_busy(o_busy), .o_overflow(o_overflow),
    .o_retired_cnt(o_retired_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [68:0] mq[$];
  int          m_phase = 0;  // 0 waiting for work, 1 offering, 2 CLP working
  logic [63:0] m_instr = '0;
  logic [4:0]  m_addr = '0;
  logic        m_valid = 1'b0, m_busy = 1'b0, m_ovf = 1'b0, m_err = 1'b0;
  logic [7:0]  m_ret = 8'd0;
  logic [68:0] m_head;
  bit          m_popped;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_phase = 0; m_instr = '0; m_addr = '0;
      m_valid = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_ret = 8'd0;
    end else begin
      m_popped = 1'b0;
      if (m_phase == 0 && mq.size() > 0) begin
        m_head = mq.pop_front();
        m_popped = 1'b1;
      end
      if (i_instr_enable) begin
        if (mq.size() < DEPTH) mq.push_back({i_instr, i_instr_addr});
        else m_ovf = 1'b1;
      end
      if (m_phase == 0) begin
        if (m_popped) begin
          m_instr = m_head[68:5];
          m_addr  = m_head[4:0];
          if (m_instr[63:57] != 7'd0) begin
`ifdef INSTR_DECODE_OPCODE_CHECK_EN
            if (m_instr[63:57] > 7'd4) m_err = 1'b1;
            else begin m_phase = 1; m_valid = 1'b1; end
`else
            m_phase = 1; m_valid = 1'b1;
`endif
          end
        end
      end else if (m_phase == 1) begin
        if (i_clp_ready) begin m_phase = 2; m_valid = 1'b0; m_busy = 1'b1; end
      end else begin
        if (i_clp_done) begin m_phase = 0; m_busy = 1'b0; m_ret = m_ret + 8'd1; end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", o_valid, m_valid);
      check("busy", o_busy, m_busy);
      check("overflow", o_overflow, m_ovf);
      check("err", o_err, m_err);
      check("retired", o_retired_cnt, m_ret);
      check("opcode", o_opcode, m_instr[63:57]);
      check("fsize", o_feature_size, m_instr[56:49]);
      check("fout", o_feature_out_select, m_instr[48]);
      check("fin", o_feature_in_select, m_instr[47]);
      check("wmem", o_w_mem_init_addr, m_instr[46:31]);
      check("smem", o_s_mem_addr, m_instr[30:23]);
      check("worktime", o_clp_work_time, m_instr[22:7]);
      check("ksize", o_kernel_size, m_instr[6:4]);
      check("ctype", o_clp_type, m_instr[3:0]);
      check("iaddr", o_instr_addr, m_addr);
    end
  end

  // Record what the DUT actually dispatches.
  logic [4:0] disp[$];
  always @(posedge clk) begin
    if (!rst && o_valid && i_clp_ready) disp.push_back(o_instr_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w, input logic [4:0] a);
    i_instr = w; i_instr_addr = a; i_instr_enable = 1'b1;
    step();
    i_instr_enable = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_ovf"}, o_overflow, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_ret"}, o_retired_cnt, 0);
    check({tag, "_opcode"}, o_opcode, 0);
    check({tag, "_iaddr"}, o_instr_addr, 0);
  endtask

  function automatic logic [63:0] mk(input logic [6:0] op, input logic [56:0] lo);
    return {op, lo};
  endfunction

  logic [6:0] held_op;
  logic [15:0] held_wmem;
  int budget;

  initial begin
    rst = 1'b1; i_instr_enable = 1'b0; i_clp_ready = 1'b0; i_clp_done = 1'b0;
    i_instr = '0; i_instr_addr = '0;
    step(); step();
    chk_en = 1'b1;
    check_all_zero("reset");
    rst = 1'b0;

    // done outside BUSY is ignored
    i_clp_done = 1'b1; step(); i_clp_done = 1'b0;
    check("stray_done_ret", o_retired_cnt, 0);

    // single instruction latency and field decode
    i_clp_ready = 1'b1;
    push(64'h0220_0000_0000_0051, 5'd0);
    check("lat_n1_valid", o_valid, 0);
    step();
    check("lat_n2_valid", o_valid, 1);
    check("single_opcode", o_opcode, 7'd1);
    check("single_fsize", o_feature_size, 8'd16);
    check("single_ksize", o_kernel_size, 3'd5);
    check("single_ctype", o_clp_type, 4'd1);
    step();
    check("single_busy", o_busy, 1);
    i_clp_done = 1'b1; step(); i_clp_done = 1'b0;
    check("single_ret", o_retired_cnt, 8'd1);

    // hold in ISSUE while CLP not ready
    i_clp_ready = 1'b0;
    push(mk(7'd3, 57'h1A2B3C4D5E6F7), 5'd1);
    step();
    held_op = o_opcode; held_wmem = o_w_mem_init_addr;
    check("stall_opcode", held_op, 7'd3);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", o_valid, 1);
      check("stall_opcode_hold", o_opcode, held_op);
      check("stall_wmem_hold", o_w_mem_init_addr, held_wmem);
    end
    i_clp_ready = 1'b1; step();
    check("stall_release_busy", o_busy, 1);
    check("stall_release_valid", o_valid, 0);
    i_clp_done = 1'b1; step(); i_clp_done = 1'b0;

    // NOP then opcode 2
    disp.delete();
    push(mk(7'd0, 57'h55), 5'd2);
    push(mk(7'd2, 57'h77), 5'd3);
    i_clp_done = 1'b1;
    repeat (12) step();
    i_clp_done = 1'b0;
    check("nop_disp_count", disp.size(), 1);
    if (disp.size() == 1) check("nop_disp_addr", disp[0], 5'd3);
    check("nop_ret", o_retired_cnt, 8'd3);

    // illegal opcode handling
    disp.delete();
    push(mk(7'h7F, 57'h3), 5'd4);
    i_clp_done = 1'b1;
    repeat (8) step();
    i_clp_done = 1'b0;
`ifdef INSTR_DECODE_OPCODE_CHECK_EN
    check("ill_disp_count", disp.size(), 0);
    check("ill_err", o_err, 1);
    check("ill_ret", o_retired_cnt, 8'd3);
`else
    check("ill_disp_count", disp.size(), 1);
    check("ill_err", o_err, 0);
    check("ill_ret", o_retired_cnt, 8'd4);
`endif

    // overflow: 16 back-to-back pushes with CLP never done
    rst = 1'b1; step(); rst = 1'b0;
    check_all_zero("rst2");
    disp.delete();
    for (int i = 0; i < 16; i++) push(mk(7'd1, 57'(i)), 5'(i));
    check("ovf_flag", o_overflow, 1);
    check("ovf_busy", o_busy, 1);
    i_clp_done = 1'b1;
    repeat (30) step();
    i_clp_done = 1'b0;
    check("ovf_disp_count", disp.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < disp.size()) check("ovf_disp_addr", disp[i], 5'(i));
    end
    check("ovf_ret", o_retired_cnt, 8'd5);
    check("ovf_sticky", o_overflow, 1);

    // reset while BUSY with three queued
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(7'd2, 57'(i + 8)), 5'(i));
    budget = 10;
    while (!o_busy && budget > 0) begin step(); budget--; end
    check("rstbusy_reached", o_busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check_all_zero("rstbusy");
    repeat (5) step();
    check("rstbusy_empty_valid", o_valid, 0);
    check("rstbusy_empty_busy", o_busy, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, instruction queue depth (power of 2, 2..16).
REQ-002 SHALL have ports, in this order:
 clk  in  1  clock, all logic on rising edge
 rst  in  1  synchronous active-high reset
 i_instr  in  64  instruction word from fetch stage
 i_instr_addr  in  5  instruction index from fetch stage
 i_instr_enable  in  1  i_instr/i_instr_addr valid this cycle (no backpressure)
 i_clp_ready  in  1  CLP can accept a dispatch
 i_clp_done  in  1  one-cycle pulse, CLP finished current instruction
 o_valid  out  1  decoded fields valid, dispatch offered
 o_opcode  out  7  instr[63:57]
 o_feature_size  out  8  instr[56:49]
 o_feature_out_select  out  1  instr[48]
 o_feature_in_select  out  1  instr[47]
 o_w_mem_init_addr  out  16  instr[46:31]
 o_s_mem_addr  out  8  instr[30:23]
 o_clp_work_time  out  16  instr[22:7]
 o_kernel_size  out  3  instr[6:4]
 o_clp_type  out  4  instr[3:0]
 o_instr_addr  out  5  index of dispatched instruction
 o_busy  out  1  instruction dispatched, awaiting i_clp_done
 o_overflow  out  1  sticky, word arrived while queue full
 o_retired_cnt  out  8  completed instructions, wraps 255->0
 o_err  out  1  sticky illegal-opcode flag (see Configuration)

Function
REQ-003 SHALL push {i_instr, i_instr_addr} into a FIFO_DEPTH-entry queue on every cycle i_instr_enable=1 and queue not full.
REQ-004 SHALL drop the word and set o_overflow when i_instr_enable=1 and queue full with no pop that cycle; simultaneous push and pop at full SHALL accept the push.
REQ-005 SHALL implement FSM states IDLE, ISSUE, BUSY.
REQ-006 IDLE: queue non-empty -> pop head, register all decoded fields and o_instr_addr; opcode 0 (NOP) -> stay IDLE, no dispatch, not retired; otherwise -> ISSUE.
REQ-007 ISSUE: o_valid=1; fields held stable; o_valid&&i_clp_ready -> BUSY next cycle.
REQ-008 BUSY: o_busy=1, o_valid=0; i_clp_done -> o_retired_cnt+1, IDLE next cycle.
REQ-009 i_clp_done outside BUSY SHALL be ignored.
REQ-010 Latency: word pushed cycle N into empty queue SHALL present o_valid=1 at cycle N+2.
REQ-011 Field outputs SHALL retain last decoded values outside ISSUE.
REQ-012 Queue pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-013 rst=1 SHALL, on the clock edge: FSM to IDLE, queue emptied, all outputs 0 (including o_overflow, o_err, o_retired_cnt), independent of current state.
REQ-014 Reset mid-BUSY SHALL abandon the in-flight instruction without incrementing o_retired_cnt.

Configuration
REQ-015 Macro INSTR_DECODE_OPCODE_CHECK_EN defined: in IDLE a popped opcode > 7'd4 SHALL be discarded (no ISSUE, not retired) and o_err set sticky.
REQ-016 Macro undefined: every non-zero opcode SHALL be dispatched; o_err SHALL be constant 0.

Verification
REQ-017 Single instr 64'h0220_0000_0000_0051 at cycle N, i_clp_ready=1 -> o_valid=1 at N+2, o_opcode=1, o_feature_size=16, o_kernel_size=5, o_clp_type=1; done pulse -> o_retired_cnt=1.
REQ-018 i_clp_ready=0 for 10 cycles in ISSUE -> o_valid held 1, fields unchanged; ready=1 -> BUSY next cycle.
REQ-019 16 back-to-back pushes, FIFO_DEPTH=4, CLP never done -> o_overflow=1, after done pulses exactly 5 instructions dispatched (1 in flight + 4 queued), addrs 0..4.
REQ-020 NOP (opcode 0) then opcode 2 -> only opcode 2 dispatched, o_retired_cnt=1 after done.
REQ-021 With INSTR_DECODE_OPCODE_CHECK_EN, opcode 7'h7F -> no o_valid, o_err=1; without macro -> dispatched, o_err=0.
REQ-022 rst during BUSY with 3 queued -> next cycle IDLE, queue empty, all outputs 0.
